dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 25000000, meaning sys_clk cycles per sweep step (0.5 s at 50 MHz); legal range 2..2^25.
REQ-002 SHALL have parameter SWEEP_MAX, default 31, meaning the sweep offset limit in steps; legal range 1..31.
REQ-003 sys_clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key_wave  input  1  single-cycle pulse, already debounced: advance waveform.
REQ-006 key_up  input  1  single-cycle pulse: raise frequency one step.
REQ-007 key_down  input  1  single-cycle pulse: lower frequency one step.
REQ-008 key_sweep  input  1  single-cycle pulse: toggle automatic sweep.
REQ-009 waveform_counter  output  2  waveform select for the DDS datapath.
REQ-010 freq_counter  output  5  positive frequency-step count.
REQ-011 freq_counter2  output  5  negative frequency-step count; net offset = freq_counter - freq_counter2, one step = 50 kHz.
REQ-012 sweep_active  output  1  high while in SWEEP_UP or SWEEP_DOWN.
REQ-013 step_strobe  output  1  one-cycle pulse coincident with each automatic sweep step.

Function
REQ-014 All outputs SHALL be registered; a key pulse sampled at edge N SHALL be reflected on outputs after edge N.
REQ-015 At least one of freq_counter and freq_counter2 SHALL be zero at all times; net offset range -31..+31.
REQ-016 Net +1 SHALL be: if freq_counter2>0, decrement freq_counter2; else if freq_counter<31, increment freq_counter; else hold (saturate).
REQ-017 Net -1 SHALL be the mirror: if freq_counter>0, decrement freq_counter; else if freq_counter2<31, increment freq_counter2; else hold.
REQ-018 key_wave SHALL increment waveform_counter modulo 4 (3 -> 0) in every state.
REQ-019 FSM states SHALL be IDLE, SWEEP_UP, SWEEP_DOWN; reset state IDLE.
REQ-020 In IDLE, key_up SHALL apply net +1 and key_down SHALL apply net -1; both together SHALL cause no change.
REQ-021 In IDLE, key_sweep SHALL go to SWEEP_UP, clear both frequency counters to 0, and load the dwell timer with DWELL_CYCLES-1.
REQ-022 In SWEEP_UP or SWEEP_DOWN, key_sweep SHALL go to IDLE, hold the current counters, and keep step_strobe low.
REQ-023 In sweep states, key_up and key_down SHALL be ignored.
REQ-024 In sweep states, the dwell timer SHALL decrement each cycle. At 0 it SHALL reload DWELL_CYCLES-1, pulse step_strobe, and apply one step: net +1 in SWEEP_UP, net -1 in SWEEP_DOWN.
REQ-025 The first step SHALL occur exactly DWELL_CYCLES cycles after the key_sweep edge, with subsequent steps every DWELL_CYCLES cycles.
REQ-026 A SWEEP_UP step that makes net = +SWEEP_MAX SHALL also transition to SWEEP_DOWN.
REQ-027 A SWEEP_DOWN step that makes net = -SWEEP_MAX SHALL also transition to SWEEP_UP.
REQ-028 key_sweep SHALL take priority over key_up, key_down and a same-cycle timer expiry: no step is taken and step_strobe stays low.
REQ-029 key_wave SHALL be applied independently in the same cycle as any other event.

Reset
REQ-030 On sys_rst_n low, asynchronously: waveform_counter=0, freq_counter=0, freq_counter2=0, sweep_active=0, step_strobe=0, dwell timer=0, state=IDLE.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep immediately.
REQ-032 After reset release, operation SHALL resume on the first rising edge.

Verification (DWELL_CYCLES=4, SWEEP_MAX=3 unless noted)
REQ-033 Four key_wave pulses from reset -> waveform_counter 1,2,3,0.
REQ-034 33 key_up pulses in IDLE -> freq_counter saturates at 31, freq_counter2=0; then 32 key_down pulses -> freq_counter=0, freq_counter2=1.
REQ-035 key_sweep -> sweep_active=1, counters 0/0; step_strobe pulses 4, 8 and 12 cycles later; net +1,+2,+3; state becomes SWEEP_DOWN; next steps give net +2,+1,0,-1,-2,-3; state becomes SWEEP_UP.
REQ-036 key_sweep in the same cycle as a timer expiry in SWEEP_UP at net +1 -> IDLE, net stays +1, no step_strobe; a simultaneous key_up and key_down then -> no change.
REQ-037 sys_rst_n pulsed low mid-sweep at net -2 with waveform 2 -> all outputs 0 immediately; no step_strobe after release.

Source files
------------

// File: rtl/dds_sweep_ctrl_if.sv
// Key pulses into and DDS control outputs out of the sweep controller.
interface dds_sweep_ctrl_if;
  logic       key_wave;
  logic       key_up;
  logic       key_down;
  logic       key_sweep;
  logic [1:0] waveform_counter;
  logic [4:0] freq_counter;
  logic [4:0] freq_counter2;
  logic       sweep_active;
  logic       step_strobe;

  modport master (
    output key_wave, key_up, key_down, key_sweep,
    input  waveform_counter, freq_counter, freq_counter2, sweep_active, step_strobe
  );

  modport slave (
    input  key_wave, key_up, key_down, key_sweep,
    output waveform_counter, freq_counter, freq_counter2, sweep_active, step_strobe
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Waveform/frequency-offset controller for a DDS: manual up/down stepping in idle,
// or an automatic triangular sweep of the offset between +/-SWEEP_MAX.
module dds_sweep_ctrl #(
  parameter int unsigned DWELL_CYCLES = 25000000,
  parameter int unsigned SWEEP_MAX    = 31
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  dds_sweep_ctrl_if.slave bus
);

  localparam int unsigned     TimerW   = $clog2(DWELL_CYCLES);
  localparam logic [TimerW-1:0] Reload = TimerW'(DWELL_CYCLES - 1);
  localparam logic [4:0]      FreqMax  = 5'd31;
  localparam logic [4:0]      SweepLim = 5'(SWEEP_MAX);

  typedef enum logic [1:0] {StIdle, StSweepUp, StSweepDown} state_e;

  state_e              state_q;
  logic [TimerW-1:0]   timer_q;
  logic [1:0]          wave_q;
  logic [4:0]          fpos_q;
  logic [4:0]          fneg_q;
  logic                active_q;
  logic                strobe_q;

  // Counter pair after a net +1 / net -1 step, saturating at +/-31.
  logic [4:0] up_pos, up_neg, dn_pos, dn_neg;
  logic       up_hits_lim, dn_hits_lim;

  always_comb begin
    up_pos = fpos_q;
    up_neg = fneg_q;
    if (fneg_q != 5'd0)        up_neg = fneg_q - 5'd1;
    else if (fpos_q != FreqMax) up_pos = fpos_q + 5'd1;

    dn_pos = fpos_q;
    dn_neg = fneg_q;
    if (fpos_q != 5'd0)        dn_pos = fpos_q - 5'd1;
    else if (fneg_q != FreqMax) dn_neg = fneg_q + 5'd1;

    up_hits_lim = (up_pos == SweepLim) && (up_neg == 5'd0);
    dn_hits_lim = (dn_neg == SweepLim) && (dn_pos == 5'd0);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      wave_q   <= 2'd0;
      fpos_q   <= 5'd0;
      fneg_q   <= 5'd0;
      active_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (bus.key_wave) wave_q <= wave_q + 2'd1;

      case (state_q)
        StIdle: begin
          if (bus.key_sweep) begin
            state_q  <= StSweepUp;
            active_q <= 1'b1;
            timer_q  <= Reload;
            fpos_q   <= 5'd0;
            fneg_q   <= 5'd0;
          end else if (bus.key_up && !bus.key_down) begin
            fpos_q <= up_pos;
            fneg_q <= up_neg;
          end else if (bus.key_down && !bus.key_up) begin
            fpos_q <= dn_pos;
            fneg_q <= dn_neg;
          end
        end
        StSweepUp, StSweepDown: begin
          // key_sweep wins over a same-cycle dwell expiry.
          if (bus.key_sweep) begin
            state_q  <= StIdle;
            active_q <= 1'b0;
          end else if (timer_q == '0) begin
            timer_q  <= Reload;
            strobe_q <= 1'b1;
            if (state_q == StSweepUp) begin
              fpos_q <= up_pos;
              fneg_q <= up_neg;
              if (up_hits_lim) state_q <= StSweepDown;
            end else begin
              fpos_q <= dn_pos;
              fneg_q <= dn_neg;
              if (dn_hits_lim) state_q <= StSweepUp;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.waveform_counter = wave_q;
  assign bus.freq_counter     = fpos_q;
  assign bus.freq_counter2    = fneg_q;
  assign bus.sweep_active     = active_q;
  assign bus.step_strobe      = strobe_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: net-offset model checked every cycle plus directed literal checks.
module tb_dds_sweep_ctrl;

  localparam int unsigned Dwell    = 4;
  localparam int unsigned SweepMax = 3;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;

  dds_sweep_ctrl_if bus ();

  dds_sweep_ctrl #(
    .DWELL_CYCLES(Dwell),
    .SWEEP_MAX   (SweepMax)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #10 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: signed net offset, mode 0 idle / +1 sweeping up / -1 sweeping down,
  // cycles remaining until the next automatic step.
  int m_net  = 0;
  int m_wave = 0;
  int m_mode = 0;
  int m_rem  = 0;
  int m_strobe = 0;

  function automatic int clamp31(input int v);
    if (v > 31) return 31;
    if (v < -31) return -31;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_net();
    return int'(bus.freq_counter) - int'(bus.freq_counter2);
  endfunction

  initial begin : model
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        m_net = 0; m_wave = 0; m_mode = 0; m_rem = 0; m_strobe = 0;
      end else begin
        m_strobe = 0;
        if (bus.key_wave) m_wave = (m_wave + 1) % 4;
        if (m_mode == 0) begin
          if (bus.key_sweep) begin
            m_mode = 1;
            m_net  = 0;
            m_rem  = Dwell;
          end else begin
            m_net = clamp31(m_net + int'(bus.key_up) - int'(bus.key_down));
          end
        end else if (bus.key_sweep) begin
          m_mode = 0;
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            m_rem    = Dwell;
            m_strobe = 1;
            m_net    = clamp31(m_net + m_mode);
            if (m_net == m_mode * int'(SweepMax)) m_mode = -m_mode;
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(posedge sys_clk);
      #1;
      if (chk_en) begin
        check("cyc_wave", int'(bus.waveform_counter), m_wave);
        check("cyc_fpos", int'(bus.freq_counter), (m_net > 0) ? m_net : 0);
        check("cyc_fneg", int'(bus.freq_counter2), (m_net < 0) ? -m_net : 0);
        check("cyc_active", int'(bus.sweep_active), (m_mode != 0) ? 1 : 0);
        check("cyc_strobe", int'(bus.step_strobe), m_strobe);
      end
    end
  end

  task automatic pulse(input bit w, input bit u, input bit d, input bit s);
    bus.key_wave = w; bus.key_up = u; bus.key_down = d; bus.key_sweep = s;
    @(negedge sys_clk);
    bus.key_wave = 1'b0; bus.key_up = 1'b0; bus.key_down = 1'b0; bus.key_sweep = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_wave"}, int'(bus.waveform_counter), 0);
    check({name, "_fpos"}, int'(bus.freq_counter), 0);
    check({name, "_fneg"}, int'(bus.freq_counter2), 0);
    check({name, "_active"}, int'(bus.sweep_active), 0);
    check({name, "_strobe"}, int'(bus.step_strobe), 0);
  endtask

  initial begin : stim
    int steps [13] = '{1, 2, 3, 2, 1, 0, -1, -2, -3, -2, -1, 0, 1};
    bus.key_wave = 1'b0; bus.key_up = 1'b0; bus.key_down = 1'b0; bus.key_sweep = 1'b0;

    #5 sys_rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk_en    = 1'b1;

    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      check("wave_seq", int'(bus.waveform_counter), (i + 1) % 4);
    end

    repeat (33) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("up_sat_fpos", int'(bus.freq_counter), 31);
    check("up_sat_fneg", int'(bus.freq_counter2), 0);
    repeat (32) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("down_fpos", int'(bus.freq_counter), 0);
    check("down_fneg", int'(bus.freq_counter2), 1);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("updown_idle_net", dut_net(), -1);

    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("sweep_start_active", int'(bus.sweep_active), 1);
    check("sweep_start_net", dut_net(), 0);
    check("sweep_start_fneg", int'(bus.freq_counter2), 0);
    for (int k = 0; k < 13; k++) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge sys_clk);
        check("dwell_no_strobe", int'(bus.step_strobe), 0);
      end
      if (k == 4) bus.key_wave = 1'b1;
      @(negedge sys_clk);
      bus.key_wave = 1'b0;
      check("step_strobe", int'(bus.step_strobe), 1);
      check("step_net", dut_net(), steps[k]);
    end

    // Sweep key lands on the same edge as the dwell expiry at net +1.
    for (int j = 0; j < 3; j++) @(negedge sys_clk);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("prio_active", int'(bus.sweep_active), 0);
    check("prio_strobe", int'(bus.step_strobe), 0);
    check("prio_net", dut_net(), 1);
    repeat (6) @(negedge sys_clk);
    check("idle_hold_net", dut_net(), 1);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("updown_hold_net", dut_net(), 1);

    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_wave", int'(bus.waveform_counter), 2);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8 * Dwell) @(negedge sys_clk);
    check("pre_rst_net", dut_net(), -2);
    check("pre_rst_active", int'(bus.sweep_active), 1);
    #3 sys_rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge sys_clk);
      check("post_rst_strobe", int'(bus.step_strobe), 0);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_wave", int'(bus.waveform_counter), 1);

    @(negedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
